// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token.
// A grant is held while its request stays high, for at most HOLD_MAX cycles.
module ring_token_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    localparam int CW      = $clog2(HOLD_MAX + 1),
    localparam int TW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          preset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [N-1:0]  token,
    output logic          busy,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [TW-1:0] tidx;
    logic [N-1:0]  pick;
    logic          found;
    logic          release_now;

    always_comb begin
        tidx = '0;
        for (int i = 0; i < N; i++) begin
            if (token[i]) tidx = i[TW-1:0];
        end
    end

    // Circular scan upward from the token position, token position included.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(tidx) + k) % N]) begin
                pick[(int'(tidx) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign release_now = !(|(req & grant)) || (hold_cnt == CW'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            token    <= {{(N-1){1'b0}}, 1'b1};
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else if (preset) begin
            state    <= IDLE;
            grant    <= '0;
            token    <= {1'b1, {(N-1){1'b0}}};
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= CW'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // Token moves just past the winner as the grant drops.
                        state    <= IDLE;
                        token    <= {grant[N-2:0], grant[N-1]};
                        grant    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
